// File: rtl/pong_draw_sequencer_pkg.sv
// Screen geometry, object sizes, colours and segment encoding shared by the Pong draw path.
// Positions are clamped on entry so rect walks never wrap past the screen edge.
package pong_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int PADDLE_W = 4;
    localparam int PADDLE_H = 32;
    localparam int BALL_SZ  = 4;
    localparam int P1_X     = 8;
    localparam int P2_X     = 308;

    localparam logic [2:0] FG_COLOUR = 3'b111;
    localparam logic [2:0] BG_COLOUR = 3'b000;

    localparam logic [7:0] PADDLE_Y_MAX = 8'(SCREEN_H - PADDLE_H);
    localparam logic [7:0] BALL_Y_MAX   = 8'(SCREEN_H - BALL_SZ);
    localparam logic [8:0] BALL_X_MAX   = 9'(SCREEN_W - BALL_SZ);

    // Segment order is the numeric order 1..7; SEEK picks the next runnable one.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_BORDER   = 4'd1,
        S_ERASE_P1 = 4'd2,
        S_ERASE_P2 = 4'd3,
        S_ERASE_B  = 4'd4,
        S_DRAW_P1  = 4'd5,
        S_DRAW_P2  = 4'd6,
        S_DRAW_B   = 4'd7,
        S_FINISH   = 4'd8,
        S_SEEK     = 4'd9
    } seg_state_t;

    typedef struct packed {
        logic [8:0] x0;
        logic [7:0] y0;
        logic [8:0] w;
        logic [7:0] h;
        logic [2:0] colour;
    } rect_t;

    function automatic logic [7:0] clamp8(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [8:0] clamp9(input logic [8:0] v, input logic [8:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/pong_draw_sequencer_if.sv
// Game-logic request/position inputs plus the vga_adapter pixel-write outputs.
// master = game side and pixel sink; slave = the draw sequencer.
interface pong_draw_sequencer_if;
    logic       start;
    logic [7:0] p1_y;
    logic [7:0] p2_y;
    logic [8:0] ball_x;
    logic [7:0] ball_y;
    logic       busy;
    logic       done;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] colour;
    logic       plot;

    modport master (output start, p1_y, p2_y, ball_x, ball_y,
                    input  busy, done, x, y, colour, plot);
    modport slave  (input  start, p1_y, p2_y, ball_x, ball_y,
                    output busy, done, x, y, colour, plot);
endinterface

// File: rtl/pong_draw_sequencer_rect_walker.sv
// Raster walker: after load, emits w*h pixels one per cycle (x inner, y outer) then idles.
// No backpressure; last flags the final pixel so the caller can reload on the next cycle.
module pong_rect_walker (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [8:0] x0,
    input  logic [7:0] y0,
    input  logic [8:0] w,
    input  logic [7:0] h,
    output logic [8:0] x,
    output logic [7:0] y,
    output logic       valid,
    output logic       last
);
    logic [8:0] xs_q, w_q, xc_q;
    logic [7:0] h_q, yc_q;

    assign last = valid && (xc_q == w_q - 9'd1) && (yc_q == h_q - 8'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x     <= '0;
            y     <= '0;
            xs_q  <= '0;
            w_q   <= '0;
            h_q   <= '0;
            xc_q  <= '0;
            yc_q  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            x     <= x0;
            y     <= y0;
            xs_q  <= x0;
            w_q   <= w;
            h_q   <= h;
            xc_q  <= '0;
            yc_q  <= '0;
            valid <= 1'b1;
        end else if (valid) begin
            if (last) begin
                valid <= 1'b0;
            end else if (xc_q == w_q - 9'd1) begin
                xc_q <= '0;
                x    <= xs_q;
                yc_q <= yc_q + 8'd1;
                y    <= y + 8'd1;
            end else begin
                xc_q <= xc_q + 9'd1;
                x    <= x + 9'd1;
            end
        end
    end
endmodule

// File: rtl/pong_draw_sequencer.sv
// Sequences border, erase and draw rectangles onto the vga_adapter port, one pixel per clock.
// One load/gap cycle per executed rect; start is ignored while busy.
module pong_draw_sequencer
    import pong_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    pong_draw_sequencer_if.slave  bus
);
    seg_state_t state_q, state_d, resume_q, resume_d;
    logic [1:0] bidx_q, bidx_d;
    logic       border_done, prev_valid, border_set, load, found;
    logic [3:0] pick;
    logic [7:0] new_p1, new_p2, new_by, prev_p1, prev_p2, prev_by;
    logic [8:0] new_bx, prev_bx;
    logic [2:0] colour_q;
    logic [7:0] run;
    rect_t      rect;
    logic [8:0] walk_x;
    logic [7:0] walk_y;
    logic       walk_valid, walk_last;

    logic chg_p1, chg_p2, chg_b;
    assign chg_p1 = (new_p1 != prev_p1);
    assign chg_p2 = (new_p2 != prev_p2);
    assign chg_b  = (new_bx != prev_bx) || (new_by != prev_by);

    assign run = {!prev_valid || chg_b, !prev_valid || chg_p2, !prev_valid || chg_p1,
                  prev_valid && chg_b, prev_valid && chg_p2, prev_valid && chg_p1,
                  !border_done, 1'b0};

    // Lowest-numbered runnable segment at or after the resume point; skipped ones cost nothing.
    always_comb begin
        found = 1'b0;
        pick  = 4'd0;
        for (int s = 7; s >= 1; s--) begin
            if (run[s] && (s >= int'(resume_q))) begin
                found = 1'b1;
                pick  = 4'(s);
            end
        end
    end

    always_comb begin
        rect = '0;
        case (pick)
            4'd1: begin
                case (bidx_q)
                    2'd0:    rect = '{9'd0,   8'd0,   9'd320, 8'd1,   FG_COLOUR};
                    2'd1:    rect = '{9'd0,   8'd239, 9'd320, 8'd1,   FG_COLOUR};
                    2'd2:    rect = '{9'd0,   8'd1,   9'd1,   8'd238, FG_COLOUR};
                    default: rect = '{9'd319, 8'd1,   9'd1,   8'd238, FG_COLOUR};
                endcase
            end
            4'd2: rect = '{9'(P1_X), prev_p1, 9'(PADDLE_W), 8'(PADDLE_H), BG_COLOUR};
            4'd3: rect = '{9'(P2_X), prev_p2, 9'(PADDLE_W), 8'(PADDLE_H), BG_COLOUR};
            4'd4: rect = '{prev_bx,  prev_by, 9'(BALL_SZ),  8'(BALL_SZ),  BG_COLOUR};
            4'd5: rect = '{9'(P1_X), new_p1,  9'(PADDLE_W), 8'(PADDLE_H), FG_COLOUR};
            4'd6: rect = '{9'(P2_X), new_p2,  9'(PADDLE_W), 8'(PADDLE_H), FG_COLOUR};
            4'd7: rect = '{new_bx,   new_by,  9'(BALL_SZ),  8'(BALL_SZ),  FG_COLOUR};
            default: rect = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            resume_q <= S_BORDER;
            bidx_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            bidx_q   <= bidx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        resume_d   = resume_q;
        bidx_d     = bidx_q;
        load       = 1'b0;
        border_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_SEEK;
                    resume_d = S_BORDER;
                    bidx_d   = 2'd0;
                end
            end
            S_SEEK: begin
                if (found) begin
                    load    = 1'b1;
                    state_d = seg_state_t'(pick);
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default: begin
                if (walk_last) begin
                    state_d = S_SEEK;
                    if (state_q == S_BORDER && bidx_q != 2'd3) begin
                        bidx_d   = bidx_q + 2'd1;
                        resume_d = S_BORDER;
                    end else if (state_q == S_BORDER) begin
                        border_set = 1'b1;
                        bidx_d     = 2'd0;
                        resume_d   = S_ERASE_P1;
                    end else begin
                        resume_d = seg_state_t'(state_q + 4'd1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            border_done <= 1'b0;
            prev_valid  <= 1'b0;
            new_p1      <= '0;
            new_p2      <= '0;
            new_bx      <= '0;
            new_by      <= '0;
            prev_p1     <= '0;
            prev_p2     <= '0;
            prev_bx     <= '0;
            prev_by     <= '0;
            colour_q    <= '0;
        end else begin
            if (state_q == S_IDLE && bus.start) begin
                new_p1 <= clamp8(bus.p1_y, PADDLE_Y_MAX);
                new_p2 <= clamp8(bus.p2_y, PADDLE_Y_MAX);
                new_bx <= clamp9(bus.ball_x, BALL_X_MAX);
                new_by <= clamp8(bus.ball_y, BALL_Y_MAX);
            end
            if (border_set) border_done <= 1'b1;
            if (load) colour_q <= rect.colour;
            if (state_q == S_FINISH) begin
                prev_p1    <= new_p1;
                prev_p2    <= new_p2;
                prev_bx    <= new_bx;
                prev_by    <= new_by;
                prev_valid <= 1'b1;
            end
        end
    end

    pong_rect_walker u_walker (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .x0    (rect.x0),
        .y0    (rect.y0),
        .w     (rect.w),
        .h     (rect.h),
        .x     (walk_x),
        .y     (walk_y),
        .valid (walk_valid),
        .last  (walk_last)
    );

    assign bus.busy   = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign bus.done   = (state_q == S_FINISH);
    assign bus.x      = walk_x;
    assign bus.y      = walk_y;
    assign bus.colour = colour_q;
    assign bus.plot   = walk_valid;
endmodule

// File: tb/tb_pong_draw_sequencer.sv
// Scoreboard bench: a rect-list model of each frame feeds an expected-pixel queue and image.
module tb_pong_draw_sequencer;
    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pong_draw_sequencer_if bus();
    pong_draw_sequencer dut (.clk(clk), .rst(rst), .bus(bus.slave));

    pix_t       exp_q[$];
    logic [2:0] exp_fb [320][240];
    logic [2:0] obs_fb [320][240];
    int n_vec = 0, n_err = 0;
    int f_plots = 0, f_busy = 0, f_done = 0;
    bit m_bd = 0, m_pv = 0;
    int m_p1 = 0, m_p2 = 0, m_bx = 0, m_by = 0;
    int m_np, m_nr;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every plotted pixel is compared with the next expected one.
    always @(negedge clk) begin
        pix_t e;
        if (bus.busy) f_busy++;
        if (bus.done) begin
            f_done++;
            check("done_while_busy", int'(bus.busy), 0);
        end
        if (bus.plot) begin
            f_plots++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pixel_unexpected: got (%0d,%0d) c=%0d, expected no pixel", bus.x, bus.y, bus.colour);
            end else begin
                e = exp_q.pop_front();
                exp_fb[e.x][e.y] = e.c;
                if (bus.x !== e.x || bus.y !== e.y || bus.colour !== e.c || bus.x > 319 || bus.y > 239 || !bus.busy) begin
                    n_err++;
                    $display("FAIL pixel: got (%0d,%0d) c=%0d busy=%0d, expected (%0d,%0d) c=%0d",
                             bus.x, bus.y, bus.colour, bus.busy, e.x, e.y, e.c);
                end
            end
            if (bus.x < 320 && bus.y < 240) obs_fb[bus.x][bus.y] = bus.colour;
        end
    end

    task automatic add_rect(input int x0, input int y0, input int w, input int h, input int c);
        pix_t p;
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++) begin
                p.x = 9'(x0 + i);
                p.y = 8'(y0 + j);
                p.c = 3'(c);
                exp_q.push_back(p);
                m_np++;
            end
        m_nr++;
    endtask

    task automatic model_frame(input int p1, input int p2, input int bx, input int by);
        int c1, c2, cx, cy;
        c1 = (p1 > 208) ? 208 : p1;
        c2 = (p2 > 208) ? 208 : p2;
        cx = (bx > 316) ? 316 : bx;
        cy = (by > 236) ? 236 : by;
        m_np = 0;
        m_nr = 0;
        if (!m_bd) begin
            add_rect(0, 0, 320, 1, 7);
            add_rect(0, 239, 320, 1, 7);
            add_rect(0, 1, 1, 238, 7);
            add_rect(319, 1, 1, 238, 7);
            m_bd = 1;
        end
        if (m_pv) begin
            if (c1 != m_p1) add_rect(8, m_p1, 4, 32, 0);
            if (c2 != m_p2) add_rect(308, m_p2, 4, 32, 0);
            if (cx != m_bx || cy != m_by) add_rect(m_bx, m_by, 4, 4, 0);
        end
        if (!m_pv || c1 != m_p1) add_rect(8, c1, 4, 32, 7);
        if (!m_pv || c2 != m_p2) add_rect(308, c2, 4, 32, 7);
        if (!m_pv || cx != m_bx || cy != m_by) add_rect(cx, cy, 4, 4, 7);
        m_p1 = c1; m_p2 = c2; m_bx = cx; m_by = cy;
        m_pv = 1;
    endtask

    task automatic fb_check();
        int d = 0;
        for (int i = 0; i < 320; i++)
            for (int j = 0; j < 240; j++)
                if (exp_fb[i][j] !== obs_fb[i][j]) d++;
        check("framebuffer_diffs", d, 0);
    endtask

    task automatic issue_start(input int p1, input int p2, input int bx, input int by);
        f_plots = 0; f_busy = 0; f_done = 0;
        @(posedge clk); #1;
        bus.p1_y = 8'(p1); bus.p2_y = 8'(p2); bus.ball_x = 9'(bx); bus.ball_y = 8'(by);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_rise", int'(bus.busy), 1);
    endtask

    task automatic run_frame(input int p1, input int p2, input int bx, input int by, input bit pulse_mid);
        int ep, er, t;
        model_frame(p1, p2, bx, by);
        ep = m_np;
        er = m_nr;
        issue_start(p1, p2, bx, by);
        if (pulse_mid) begin
            repeat (4) @(posedge clk);
            #1;
            bus.p1_y = 8'(p1 + 50); bus.ball_x = 9'(bx + 7);
            bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        t = 0;
        while (f_done == 0 && t < 5000) begin
            @(negedge clk); #1;
            t++;
        end
        check("done_seen", int'(f_done > 0), 1);
        repeat (3) @(negedge clk);
        #1;
        check("plot_count", f_plots, ep);
        check("busy_cycles", f_busy, 1 + ep + er);
        check("done_count", f_done, 1);
        check("queue_left", exp_q.size(), 0);
        check("idle_after", int'(bus.busy), 0);
        fb_check();
    endtask

    initial begin
        int found, p1, p2, bx, by;
        for (int i = 0; i < 320; i++)
            for (int j = 0; j < 240; j++) begin
                exp_fb[i][j] = 3'd0;
                obs_fb[i][j] = 3'd0;
            end
        bus.start = 1'b0; bus.p1_y = '0; bus.p2_y = '0; bus.ball_x = '0; bus.ball_y = '0;
        #3;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_plot", int'(bus.plot), 0);
        check("rst_x", int'(bus.x), 0);
        check("rst_y", int'(bus.y), 0);
        check("rst_colour", int'(bus.colour), 0);
        #20 rst = 1'b1;

        run_frame(100, 100, 158, 118, 0);
        run_frame(100, 100, 158, 118, 0);
        run_frame(100, 100, 160, 118, 0);
        run_frame(250, 0, 160, 118, 0);
        run_frame(60, 120, 40, 200, 1);

        for (int k = 0; k < 8; k++) begin
            p1 = ($urandom_range(0, 2) == 0) ? m_p1 : int'($urandom_range(0, 255));
            p2 = ($urandom_range(0, 2) == 0) ? m_p2 : int'($urandom_range(0, 255));
            bx = ($urandom_range(0, 2) == 0) ? m_bx : int'($urandom_range(0, 511));
            by = ($urandom_range(0, 2) == 0) ? m_by : int'($urandom_range(0, 255));
            run_frame(p1, p2, bx, by, 0);
        end

        // Reset during an erase rect.
        model_frame((m_p1 + 20) % 200, (m_p2 + 20) % 200, (m_bx + 20) % 300, (m_by + 20) % 200);
        issue_start(m_p1, m_p2, m_bx, m_by);
        found = 0;
        for (int t = 0; t < 3000 && found == 0; t++) begin
            @(negedge clk); #1;
            if (bus.plot && bus.colour == 3'd0) found = 1;
        end
        check("erase_seen", found, 1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_plot", int'(bus.plot), 0);
        check("midrst_busy", int'(bus.busy), 0);
        exp_q.delete();
        m_bd = 0; m_pv = 0; m_p1 = 0; m_p2 = 0; m_bx = 0; m_by = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        fb_check();
        run_frame(100, 100, 158, 118, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
